// File: rtl/serial_fas.sv
// Bit-serial N-bit adder/subtractor: one fas cell plus a carry flip-flop, LSB first.
// Latches operands on start, produces one result bit per clock, and pulses done after N cycles.

module fas (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);
  logic b_eff;

  // Subtract folds into the add path by inverting B; the caller seeds cin with 1.
  assign b_eff = b ^ ~a_ns;
  assign s     = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (cin & (a ^ b_eff));
endmodule

module serial_fas #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         a_ns,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_sr, b_sr;
  logic [N-2:0]  r_sr;
  logic [N-1:0]  res_next;
  logic          ns_q;
  logic          carry_q;
  logic [CW-1:0] cnt;
  logic          last;
  logic          bit_s, bit_c;

  fas u_fas (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .a_ns (ns_q),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign last     = (cnt == CW'(N - 1));
  assign res_next = {bit_s, r_sr};

  // Overflow: carry into the MSB differs from the carry out of it.
  function automatic logic calc_ovf(input logic c_in_msb, input logic c_out_msb);
    return c_in_msb ^ c_out_msb;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      ns_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            ns_q    <= a_ns;
            carry_q <= ~a_ns;
            cnt     <= '0;
          end
        end
        RUN: begin
          a_sr    <= {1'b0, a_sr[N-1:1]};
          b_sr    <= {1'b0, b_sr[N-1:1]};
          r_sr    <= res_next[N-1:1];
          carry_q <= bit_c;
          cnt     <= cnt + CW'(1);
          // The MSB is processed on this edge, so the result is complete here.
          if (last) begin
            s    <= res_next;
            cout <= bit_c;
            ovf  <= calc_ovf(carry_q, bit_c);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_fas.sv
// Directed-vector bench for serial_fas (N=8): arithmetic boundaries, handshake and reset abort.

module tb_serial_fas;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         a_ns;
  logic         busy, done, cout, ovf;
  logic [N-1:0] s;

  int n_checks = 0;
  int n_fail   = 0;

  serial_fas #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .a_ns (a_ns),
    .busy (busy),
    .done (done),
    .s    (s),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  // Drive a request, let edge E0 accept it, return 1 ns after E0 with start low.
  task automatic do_start(input logic [N-1:0] va, input logic [N-1:0] vb, input logic ns);
    a = va; b = vb; a_ns = ns; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (bounded), and how many samples had busy high.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; a_ns = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL reset_s: got %h want 00", s); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic;
    int cyc, bc;
    do_start(8'h01, 8'h01, 1'b1);
    wait_done(cyc, bc);
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL add_latency: got %0d want 8", cyc); end
    n_checks++; if (bc !== 8) begin n_fail++; $display("FAIL add_busy_cycles: got %0d want 8", bc); end
    n_checks++; if (s !== 8'h02) begin n_fail++; $display("FAIL add_s: got %h want 02", s); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL add_cout: got %b want 0", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %b want 0", ovf); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_done: got %b want 0", busy); end
  endtask

  task automatic test_sub_basic;
    int cyc, bc;
    do_start(8'h01, 8'h01, 1'b0);
    wait_done(cyc, bc);
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL sub_latency: got %0d want 8", cyc); end
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL sub_s: got %h want 00", s); end
    n_checks++; if (cout !== 1'b1) begin n_fail++; $display("FAIL sub_cout: got %b want 1", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sub_ovf: got %b want 0", ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_bounds;
    int cyc, bc;
    do_start(8'hFF, 8'h01, 1'b1);
    wait_done(cyc, bc);
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL addFF_s: got %h want 00", s); end
    n_checks++; if (cout !== 1'b1) begin n_fail++; $display("FAIL addFF_cout: got %b want 1", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL addFF_ovf: got %b want 0", ovf); end
    @(posedge clk); #1;
    do_start(8'h7F, 8'h01, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL hold_s_during_run: got %h want 00", s); end
    n_checks++; if (cout !== 1'b1) begin n_fail++; $display("FAIL hold_cout_during_run: got %b want 1", cout); end
    wait_done(cyc, bc);
    n_checks++; if (s !== 8'h80) begin n_fail++; $display("FAIL add7F_s: got %h want 80", s); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL add7F_cout: got %b want 0", cout); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL add7F_ovf: got %b want 1", ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub_bounds;
    int cyc, bc;
    do_start(8'h00, 8'h01, 1'b0);
    wait_done(cyc, bc);
    n_checks++; if (s !== 8'hFF) begin n_fail++; $display("FAIL sub00_s: got %h want FF", s); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL sub00_cout: got %b want 0", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sub00_ovf: got %b want 0", ovf); end
    @(posedge clk); #1;
    do_start(8'h80, 8'h01, 1'b0);
    wait_done(cyc, bc);
    n_checks++; if (s !== 8'h7F) begin n_fail++; $display("FAIL sub80_s: got %h want 7F", s); end
    n_checks++; if (cout !== 1'b1) begin n_fail++; $display("FAIL sub80_cout: got %b want 1", cout); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sub80_ovf: got %b want 1", ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored;
    int cyc;
    a = 8'h11; b = 8'h22; a_ns = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done && cyc < 20) begin
      a = a + 8'h35; b = b ^ 8'hA5; a_ns = ~a_ns;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL ignore_latency: got %0d want 8", cyc); end
    n_checks++; if (s !== 8'h33) begin n_fail++; $display("FAIL ignore_s: got %h want 33", s); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL ignore_cout: got %b want 0", cout); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    do_start(8'h01, 8'h02, 1'b1);
    wait_done(cyc, bc);
    n_checks++; if (s !== 8'h03) begin n_fail++; $display("FAIL b2b_first_s: got %h want 03", s); end
    a = 8'h10; b = 8'h20; a_ns = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b want 0", done); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
    wait_done(cyc, bc);
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL b2b_latency: got %0d want 8", cyc); end
    n_checks++; if (s !== 8'h30) begin n_fail++; $display("FAIL b2b_second_s: got %h want 30", s); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int cyc, bc, pulses;
    do_start(8'hC0, 8'h40, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL abort_s: got %h want 00", s); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL abort_cout: got %b want 0", cout); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL abort_ovf: got %b want 0", ovf); end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      @(posedge clk); #1;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    do_start(8'h05, 8'h03, 1'b1);
    wait_done(cyc, bc);
    n_checks++; if (s !== 8'h08) begin n_fail++; $display("FAIL post_abort_s: got %h want 08", s); end
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL post_abort_latency: got %0d want 8", cyc); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_add_basic;
    test_sub_basic;
    test_add_bounds;
    test_sub_bounds;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
